uart_rx_fifo: RTL and testbench

Receive-side byte buffer that sits directly downstream of the unbuffered UART receivers. It captures each byte on the rising edge of the receiver's completion strobe, stores it in a 2^aw-deep circular FIFO, and presents it to the consumer through a read-strobe handshake. It also exposes fill status and a sticky overflow flag, so slow consumers do not lose bytes silently.

---
 rtl/uart_rx_fifo_if.sv | 25 ++
 rtl/uart_rx_fifo.sv | 94 +++++++++
 tb/tb_uart_rx_fifo.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_fifo_if.sv
// Byte/handshake bundle between the UART receive FIFO and its producer/consumer.
// The FIFO takes the slave view; whoever feeds and drains it takes the master view.
interface uart_rx_fifo_if #(
    parameter int aw = 4
);
    logic [7:0]  in_data;
    logic        in_stb;
    logic        rd;
    logic        ovf_clr;
    logic [7:0]  out;
    logic        empty;
    logic        full;
    logic [aw:0] count;
    logic        ovf;

    modport master (
        output in_data, in_stb, rd, ovf_clr,
        input  out, empty, full, count, ovf
    );

    modport slave (
        input  in_data, in_stb, rd, ovf_clr,
        output out, empty, full, count, ovf
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO: captures a byte on each rising edge of the receiver strobe.
// Define UART_RX_FIFO_FWFT_EN for first-word fall-through; the default build uses a registered read.
module uart_rx_fifo #(
    parameter int aw = 4
) (
    input logic          clk,
    input logic          dr_rst,
    uart_rx_fifo_if.slave bus
);
    localparam int unsigned depth = 2 ** aw;
    localparam logic [aw:0] depth_c = (aw + 1)'(depth);

    logic [7:0]    mem [depth];
    logic [aw-1:0] wp;
    logic [aw-1:0] rp;
    logic [aw:0]   count_q;
    logic [aw:0]   count_nxt;
    logic          empty_q;
    logic          full_q;
    logic          ovf_q;
    logic          stb_q;

    logic wr_ev;
    logic pop;
    logic push;
    logic ovf_ev;

    // A full FIFO still accepts a byte when the same cycle frees a slot.
    assign wr_ev  = bus.in_stb & ~stb_q;
    assign pop    = bus.rd & ~empty_q;
    assign push   = wr_ev & (~full_q | pop);
    assign ovf_ev = wr_ev & full_q & ~pop;

    always_comb begin
        count_nxt = count_q;
        case ({push, pop})
            2'b10:   count_nxt = count_q + 1'b1;
            2'b01:   count_nxt = count_q - 1'b1;
            default: count_nxt = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge dr_rst) begin
        if (dr_rst) begin
            stb_q   <= 1'b1;
            wp      <= '0;
            rp      <= '0;
            count_q <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            stb_q   <= bus.in_stb;
            if (push) wp <= wp + 1'b1;
            if (pop)  rp <= rp + 1'b1;
            count_q <= count_nxt;
            empty_q <= (count_nxt == '0);
            full_q  <= (count_nxt == depth_c);
            if (ovf_ev)
                ovf_q <= 1'b1;
            else if (bus.ovf_clr)
                ovf_q <= 1'b0;
        end
    end

    // NOTE: the storage array has no reset; count/pointers define what is
    // valid, and leaving it unreset lets it map onto plain RAM.
    always_ff @(posedge clk) begin
        if (push) mem[wp] <= bus.in_data;
    end

`ifdef UART_RX_FIFO_FWFT_EN
    // Forced to zero while empty so reset and drain show a clean output.
    assign bus.out = empty_q ? 8'h00 : mem[rp];
`else
    logic [7:0] out_q;

    always_ff @(posedge clk or posedge dr_rst) begin
        if (dr_rst)
            out_q <= 8'h00;
        else if (pop)
            out_q <= mem[rp];
    end

    assign bus.out = out_q;
`endif

    assign bus.empty = empty_q;
    assign bus.full  = full_q;
    assign bus.count = count_q;
    assign bus.ovf   = ovf_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo with a 4-entry FIFO; follows UART_RX_FIFO_FWFT_EN
// to choose between same-cycle and one-clock read latency.
module tb_uart_rx_fifo;
    localparam int aw = 2;

    logic clk;
    logic dr_rst;
    int   n_checks;
    int   n_fail;

    uart_rx_fifo_if #(.aw(aw)) bus ();

    uart_rx_fifo #(.aw(aw)) dut (
        .clk    (clk),
        .dr_rst (dr_rst),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        bus.in_data = b;
        bus.in_stb  = 1'b1;
        tick();
        bus.in_stb  = 1'b0;
        tick();
    endtask

    task automatic read_byte(input string tag, input logic [7:0] exp);
`ifdef UART_RX_FIFO_FWFT_EN
        check(tag, 32'(bus.out), 32'(exp));
        bus.rd = 1'b1;
        tick();
        bus.rd = 1'b0;
`else
        bus.rd = 1'b1;
        tick();
        bus.rd = 1'b0;
        check(tag, 32'(bus.out), 32'(exp));
`endif
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        dr_rst      = 1'b1;
        bus.in_data = 8'h00;
        bus.in_stb  = 1'b0;
        bus.rd      = 1'b0;
        bus.ovf_clr = 1'b0;
        tick();
        check("rst_count", 32'(bus.count), 0);
        check("rst_empty", 32'(bus.empty), 1);
        check("rst_full",  32'(bus.full),  0);
        check("rst_ovf",   32'(bus.ovf),   0);
        check("rst_out",   32'(bus.out),   0);
        dr_rst = 1'b0;
        tick();

        // Basic ordering
        push_byte(8'h41);
        push_byte(8'h42);
        push_byte(8'h43);
        check("three_count", 32'(bus.count), 3);
        check("three_empty", 32'(bus.empty), 0);
        read_byte("rd_41", 8'h41);
        read_byte("rd_42", 8'h42);
        read_byte("rd_43", 8'h43);
        check("drain_empty", 32'(bus.empty), 1);
        check("drain_count", 32'(bus.count), 0);

        // Long strobe writes once
        bus.in_data = 8'h55;
        bus.in_stb  = 1'b1;
        repeat (10) tick();
        bus.in_stb  = 1'b0;
        tick();
        check("long_stb_count", 32'(bus.count), 1);
        read_byte("rd_55", 8'h55);
        check("long_stb_drain", 32'(bus.count), 0);

        // Strobe held through reset release is not a write
        bus.in_data = 8'h66;
        bus.in_stb  = 1'b1;
        dr_rst      = 1'b1;
        tick();
        dr_rst      = 1'b0;
        repeat (3) tick();
        bus.in_stb  = 1'b0;
        tick();
        check("stb_rst_count", 32'(bus.count), 0);
        check("stb_rst_empty", 32'(bus.empty), 1);

        // Fill, overflow, drain
        for (int i = 0; i < 4; i++) push_byte(8'h10 + 8'(i));
        check("fill_full",  32'(bus.full),  1);
        check("fill_count", 32'(bus.count), 4);
        push_byte(8'h99);
        check("ovf_set",   32'(bus.ovf),   1);
        check("ovf_count", 32'(bus.count), 4);
        for (int i = 0; i < 4; i++) read_byte("ovf_rd", 8'h10 + 8'(i));
        check("ovf_drain_empty", 32'(bus.empty), 1);
        check("ovf_sticky", 32'(bus.ovf), 1);
        bus.ovf_clr = 1'b1;
        tick();
        bus.ovf_clr = 1'b0;
        check("ovf_clr", 32'(bus.ovf), 0);

        // Overflow and clear in the same cycle: set wins
        for (int i = 0; i < 4; i++) push_byte(8'h20 + 8'(i));
        bus.in_data = 8'h77;
        bus.in_stb  = 1'b1;
        bus.ovf_clr = 1'b1;
        tick();
        bus.in_stb  = 1'b0;
        bus.ovf_clr = 1'b0;
        tick();
        check("ovf_set_wins", 32'(bus.ovf), 1);
        bus.ovf_clr = 1'b1;
        tick();
        bus.ovf_clr = 1'b0;
        check("ovf_clr2", 32'(bus.ovf), 0);

        // Full FIFO, pop and push together
        bus.in_data = 8'hA5;
        bus.in_stb  = 1'b1;
        bus.rd      = 1'b1;
`ifdef UART_RX_FIFO_FWFT_EN
        check("fullrw_head", 32'(bus.out), 32'h20);
`endif
        tick();
        bus.in_stb  = 1'b0;
        bus.rd      = 1'b0;
`ifndef UART_RX_FIFO_FWFT_EN
        check("fullrw_head", 32'(bus.out), 32'h20);
`endif
        tick();
        check("fullrw_count", 32'(bus.count), 4);
        check("fullrw_ovf",   32'(bus.ovf),   0);
        read_byte("fullrw_21", 8'h21);
        read_byte("fullrw_22", 8'h22);
        read_byte("fullrw_23", 8'h23);
        read_byte("fullrw_A5", 8'hA5);
        check("fullrw_drain", 32'(bus.count), 0);

        // Empty FIFO, read ignored, write stored
        bus.in_data = 8'h3C;
        bus.in_stb  = 1'b1;
        bus.rd      = 1'b1;
        tick();
        bus.in_stb  = 1'b0;
        bus.rd      = 1'b0;
        tick();
        check("emptyrw_count", 32'(bus.count), 1);
`ifndef UART_RX_FIFO_FWFT_EN
        check("emptyrw_hold", 32'(bus.out), 32'hA5);
`endif
        read_byte("emptyrw_3C", 8'h3C);
        check("emptyrw_drain", 32'(bus.count), 0);

        // Pointer wrap across 20 write/read pairs
        push_byte(8'hC0);
        for (int i = 0; i < 20; i++) begin
            push_byte(8'(i * 7 + 3));
            read_byte("wrap_rd", (i == 0) ? 8'hC0 : 8'((i - 1) * 7 + 3));
        end
        read_byte("wrap_last", 8'(19 * 7 + 3));
        check("wrap_drain", 32'(bus.count), 0);

        // Asynchronous reset with data and ovf pending
        for (int i = 0; i < 5; i++) push_byte(8'hE0 + 8'(i));
        read_byte("arst_rd0", 8'hE0);
        read_byte("arst_rd1", 8'hE1);
        check("arst_pre_count", 32'(bus.count), 2);
        check("arst_pre_ovf",   32'(bus.ovf),   1);
        #2;
        dr_rst = 1'b1;
        #1;
        check("arst_empty", 32'(bus.empty), 1);
        check("arst_count", 32'(bus.count), 0);
        check("arst_out",   32'(bus.out),   0);
        check("arst_ovf",   32'(bus.ovf),   0);
        check("arst_full",  32'(bus.full),  0);
        tick();
        dr_rst = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
